// File: rtl/ejection_sink_if.sv
// Flit ejection and credit-return signals between a router's local output port
// and the terminal sink attached to it.
interface ejection_sink_if #(
  parameter int VC_BITS  = 2,
  parameter int DST_BITS = 4
);
  logic                flit_valid;
  logic [VC_BITS-1:0]  flit_vc;
  logic                flit_head;
  logic                flit_tail;
  logic [DST_BITS-1:0] flit_dst;
  logic                cr_valid;
  logic [VC_BITS-1:0]  cr_vc;

  modport master (
    output flit_valid, flit_vc, flit_head, flit_tail, flit_dst,
    input  cr_valid, cr_vc
  );

  modport slave (
    input  flit_valid, flit_vc, flit_head, flit_tail, flit_dst,
    output cr_valid, cr_vc
  );
endinterface

// File: rtl/ejection_sink.sv
// Terminal consumer on a router ejection port: reassembles packets per VC, flags
// protocol errors, returns delayed credits and reports completion via done_o.
module ejection_sink #(
  parameter int NUM_VC       = 4,
  parameter int VC_BITS      = 2,
  parameter int DST_BITS     = 4,
  parameter int ROUTER_ID    = 0,
  parameter int CREDIT_DELAY = 2,
  parameter int CNT_BITS     = 16,
  parameter int CYC_BITS     = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  ejection_sink_if.slave      ej,
  input  logic [CYC_BITS-1:0] in_cycle_i,
  input  logic [CNT_BITS-1:0] expected_pkts_i,
  output logic [CNT_BITS-1:0] flit_count_o,
  output logic [CNT_BITS-1:0] pkt_count_o,
  output logic [CNT_BITS-1:0] err_count_o,
  output logic [3:0]          err_flags_o,
  output logic [CYC_BITS-1:0] last_tail_cycle_o,
  output logic                done_o
);

  localparam int                   VC_SLOTS   = 1 << VC_BITS;
  localparam logic [VC_BITS:0]     NUM_VC_W   = (VC_BITS+1)'(NUM_VC);
  localparam logic [DST_BITS-1:0]  ROUTER_DST = DST_BITS'(ROUTER_ID);
  localparam logic [CNT_BITS-1:0]  CNT_MAX    = '1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } vc_state_e;

  logic                vc_in_range;
  logic                accept;
  logic                bad_vc;
  logic                sel_busy;
  logic                nested;
  logic                orphan;
  logic                misroute;
  logic                pkt_done;
  logic                err_hit;
  logic [3:0]          err_set;
  logic [VC_SLOTS-1:0] busy_vec;

  logic [CNT_BITS-1:0] flit_count_q;
  logic [CNT_BITS-1:0] pkt_count_q;
  logic [CNT_BITS-1:0] err_count_q;
  logic [3:0]          err_flags_q;
  logic [CYC_BITS-1:0] last_tail_cycle_q;
  logic                done_q;

  logic [CREDIT_DELAY-1:0] cr_v_q;
  logic [VC_BITS-1:0]      cr_vc_q [CREDIT_DELAY];

  // Classify the incoming flit against the state of the VC it targets.
  always_comb begin
    vc_in_range = ({1'b0, ej.flit_vc} < NUM_VC_W);
    accept      = ej.flit_valid && vc_in_range;
    bad_vc      = ej.flit_valid && !vc_in_range;
    sel_busy    = busy_vec[ej.flit_vc];
    nested      = accept && ej.flit_head && sel_busy;
    orphan      = accept && !ej.flit_head && !sel_busy;
    misroute    = accept && ej.flit_head && (ej.flit_dst != ROUTER_DST);
    pkt_done    = accept && ej.flit_tail && (ej.flit_head || sel_busy);
    err_hit     = bad_vc || nested || orphan || misroute;

    // One error class per flit, highest priority wins.
    err_set = 4'b0000;
    if (bad_vc) begin
      err_set[3] = 1'b1;
    end else if (nested) begin
      err_set[1] = 1'b1;
    end else if (orphan) begin
      err_set[0] = 1'b1;
    end else if (misroute) begin
      err_set[2] = 1'b1;
    end
  end

  // Slots at or above NUM_VC are never selected and stay idle.
  genvar gi;
  generate
    for (gi = 0; gi < VC_SLOTS; gi++) begin : g_vc
      vc_state_e state_q;
      vc_state_e state_d;
      logic      vc_sel;

      assign vc_sel       = accept && (ej.flit_vc == VC_BITS'(gi));
      assign busy_vec[gi] = (state_q == ST_BUSY);

      always_comb begin
        state_d = state_q;
        if (vc_sel && (ej.flit_head || state_q == ST_BUSY)) begin
          state_d = ej.flit_tail ? ST_IDLE : ST_BUSY;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          state_q <= ST_IDLE;
        end else begin
          state_q <= state_d;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flit_count_q      <= '0;
      pkt_count_q       <= '0;
      err_count_q       <= '0;
      err_flags_q       <= '0;
      last_tail_cycle_q <= '0;
      done_q            <= 1'b0;
    end else begin
      if (ej.flit_valid && flit_count_q != CNT_MAX) begin
        flit_count_q <= flit_count_q + CNT_BITS'(1);
      end
      if (pkt_done) begin
        last_tail_cycle_q <= in_cycle_i;
        if (pkt_count_q != CNT_MAX) begin
          pkt_count_q <= pkt_count_q + CNT_BITS'(1);
        end
      end
      if (err_hit && err_count_q != CNT_MAX) begin
        err_count_q <= err_count_q + CNT_BITS'(1);
      end
      err_flags_q <= err_flags_q | err_set;
      done_q      <= (pkt_count_q == expected_pkts_i) && (busy_vec == '0);
    end
  end

  // Credit return: stage 0 captures the accepted flit, the last stage drives the port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cr_v_q <= '0;
      for (int i = 0; i < CREDIT_DELAY; i++) begin
        cr_vc_q[i] <= '0;
      end
    end else begin
      cr_v_q[0]  <= accept;
      cr_vc_q[0] <= accept ? ej.flit_vc : '0;
      for (int i = 1; i < CREDIT_DELAY; i++) begin
        cr_v_q[i]  <= cr_v_q[i-1];
        cr_vc_q[i] <= cr_vc_q[i-1];
      end
    end
  end

  assign ej.cr_valid        = cr_v_q[CREDIT_DELAY-1];
  assign ej.cr_vc           = cr_vc_q[CREDIT_DELAY-1];
  assign flit_count_o       = flit_count_q;
  assign pkt_count_o        = pkt_count_q;
  assign err_count_o        = err_count_q;
  assign err_flags_o        = err_flags_q;
  assign last_tail_cycle_o  = last_tail_cycle_q;
  assign done_o             = done_q;

endmodule

// File: tb/tb_ejection_sink.sv
// Randomized and directed bench for ejection_sink: two instances (4 VCs / 16-bit
// counters, and 3 VCs / 4-bit counters / 3-cycle credits) against a packet-level model.
module tb_ejection_sink;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        f_valid = 1'b0;
  logic [1:0]  f_vc = '0;
  logic        f_head = 1'b0;
  logic        f_tail = 1'b0;
  logic [3:0]  f_dst = '0;
  logic [15:0] cyc = '0;
  logic [15:0] exp_a = '0;
  logic [3:0]  exp_b = '0;

  logic [15:0] fc_a, pc_a, ec_a, lt_a;
  logic [3:0]  ef_a;
  logic        done_a;
  logic [3:0]  fc_b, pc_b, ec_b, ef_b;
  logic [15:0] lt_b;
  logic        done_b;

  always #5 clk = ~clk;

  ejection_sink_if #(.VC_BITS(2), .DST_BITS(4)) if_a ();
  ejection_sink_if #(.VC_BITS(2), .DST_BITS(4)) if_b ();

  assign if_a.flit_valid = f_valid;
  assign if_a.flit_vc    = f_vc;
  assign if_a.flit_head  = f_head;
  assign if_a.flit_tail  = f_tail;
  assign if_a.flit_dst   = f_dst;
  assign if_b.flit_valid = f_valid;
  assign if_b.flit_vc    = f_vc;
  assign if_b.flit_head  = f_head;
  assign if_b.flit_tail  = f_tail;
  assign if_b.flit_dst   = f_dst;

  ejection_sink #(
    .NUM_VC(4), .VC_BITS(2), .DST_BITS(4), .ROUTER_ID(0),
    .CREDIT_DELAY(2), .CNT_BITS(16), .CYC_BITS(16)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .ej(if_a), .in_cycle_i(cyc), .expected_pkts_i(exp_a),
    .flit_count_o(fc_a), .pkt_count_o(pc_a), .err_count_o(ec_a), .err_flags_o(ef_a),
    .last_tail_cycle_o(lt_a), .done_o(done_a)
  );

  ejection_sink #(
    .NUM_VC(3), .VC_BITS(2), .DST_BITS(4), .ROUTER_ID(5),
    .CREDIT_DELAY(3), .CNT_BITS(4), .CYC_BITS(16)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .ej(if_b), .in_cycle_i(cyc), .expected_pkts_i(exp_b),
    .flit_count_o(fc_b), .pkt_count_o(pc_b), .err_count_o(ec_b), .err_flags_o(ef_b),
    .last_tail_cycle_o(lt_b), .done_o(done_b)
  );

  // Reference model, indexed by instance (0 = A, 1 = B).
  int       m_num_vc [2] = '{4, 3};
  int       m_delay  [2] = '{2, 3};
  int       m_rid    [2] = '{0, 5};
  int       m_max    [2] = '{65535, 15};
  bit       m_open   [2][4];
  int       m_flits  [2];
  int       m_pkts   [2];
  int       m_errs   [2];
  bit [3:0] m_flags  [2];
  int       m_last   [2];
  bit       m_done   [2];
  bit       m_crv    [2][16];
  int       m_crvc   [2][16];
  int       edge_n = 0;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, edge_n);
    end
  endtask

  function automatic int sat_inc(input int v, input int mx);
    return (v >= mx) ? mx : v + 1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_flits[d] = 0;
      m_pkts[d]  = 0;
      m_errs[d]  = 0;
      m_flags[d] = '0;
      m_last[d]  = 0;
      m_done[d]  = 1'b0;
      for (int v = 0; v < 4; v++) m_open[d][v] = 1'b0;
      for (int s = 0; s < 16; s++) begin
        m_crv[d][s]  = 1'b0;
        m_crvc[d][s] = 0;
      end
    end
  endtask

  task automatic model_err(input int d, input int bit_idx);
    m_flags[d][bit_idx] = 1'b1;
    m_errs[d] = sat_inc(m_errs[d], m_max[d]);
  endtask

  task automatic model_complete(input int d);
    m_pkts[d] = sat_inc(m_pkts[d], m_max[d]);
    m_last[d] = int'(cyc);
  endtask

  // One rising edge for one instance, using the rules at packet level.
  task automatic model_edge(input int d);
    bit any_open = 1'b0;
    int want;
    int v = int'(f_vc);
    bit next_done;
    for (int k = 0; k < 4; k++) any_open |= m_open[d][k];
    want = (d == 0) ? int'(exp_a) : int'(exp_b);
    next_done = (m_pkts[d] == want) && !any_open;
    if (f_valid) begin
      m_flits[d] = sat_inc(m_flits[d], m_max[d]);
      if (v >= m_num_vc[d]) begin
        model_err(d, 3);
      end else begin
        m_crv[d][(edge_n + m_delay[d] - 1) % 16]  = 1'b1;
        m_crvc[d][(edge_n + m_delay[d] - 1) % 16] = v;
        if (f_head) begin
          if (m_open[d][v]) model_err(d, 1);
          else if (int'(f_dst) != m_rid[d]) model_err(d, 2);
          if (f_tail) begin
            model_complete(d);
            m_open[d][v] = 1'b0;
          end else begin
            m_open[d][v] = 1'b1;
          end
        end else if (!m_open[d][v]) begin
          model_err(d, 0);
        end else if (f_tail) begin
          model_complete(d);
          m_open[d][v] = 1'b0;
        end
      end
    end
    m_done[d] = next_done;
  endtask

  task automatic check_dut(input int d, input logic [31:0] fc, input logic [31:0] pc,
                           input logic [31:0] ec, input logic [31:0] ef, input logic [31:0] lt,
                           input logic [31:0] crv, input logic [31:0] crvc, input logic [31:0] dn);
    string p = (d == 0) ? "A" : "B";
    int    s = edge_n % 16;
    check_eq({p, ".flit_count"}, fc, m_flits[d]);
    check_eq({p, ".pkt_count"}, pc, m_pkts[d]);
    check_eq({p, ".err_count"}, ec, m_errs[d]);
    check_eq({p, ".err_flags"}, ef, 32'(m_flags[d]));
    check_eq({p, ".last_tail_cycle"}, lt, m_last[d]);
    check_eq({p, ".cr_valid"}, crv, 32'(m_crv[d][s]));
    if (m_crv[d][s]) check_eq({p, ".cr_vc"}, crvc, m_crvc[d][s]);
    check_eq({p, ".done"}, dn, 32'(m_done[d]));
  endtask

  task automatic check_all();
    check_dut(0, 32'(fc_a), 32'(pc_a), 32'(ec_a), 32'(ef_a), 32'(lt_a),
              32'(if_a.cr_valid), 32'(if_a.cr_vc), 32'(done_a));
    check_dut(1, 32'(fc_b), 32'(pc_b), 32'(ec_b), 32'(ef_b), 32'(lt_b),
              32'(if_b.cr_valid), 32'(if_b.cr_vc), 32'(done_b));
  endtask

  task automatic step();
    @(posedge clk);
    edge_n++;
    if (f_valid) begin
      $display("[edge %0d] flit vc=%0d head=%0b tail=%0b dst=%0d cycle=%0d",
               edge_n, f_vc, f_head, f_tail, f_dst, cyc);
    end
    if (rst_n) begin
      model_edge(0);
      model_edge(1);
    end
    @(negedge clk);
    check_all();
    for (int d = 0; d < 2; d++) m_crv[d][edge_n % 16] = 1'b0;
  endtask

  task automatic send(input bit v, input int vc, input bit h, input bit t, input int dst,
                      input int cy);
    f_valid = v;
    f_vc    = 2'(vc);
    f_head  = h;
    f_tail  = t;
    f_dst   = 4'(dst);
    cyc     = 16'(cy);
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) send(1'b0, 0, 1'b0, 1'b0, 0, edge_n);
  endtask

  // Called at a falling edge: assert reset mid-cycle, check outputs clear at once.
  task automatic do_reset(input int ea, input int eb);
    f_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    exp_a = 16'(ea);
    exp_b = 4'(eb);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    @(negedge clk);

    // Single-flit packet at cycle 10.
    do_reset(1, 1);
    send(1'b1, 1, 1'b1, 1'b1, 0, 10);
    idle(4);

    // Interleaved 4-flit packet on vc0 and 3-flit packet on vc2.
    do_reset(2, 2);
    send(1'b1, 0, 1'b1, 1'b0, 0, 100);
    send(1'b1, 2, 1'b1, 1'b0, 0, 101);
    send(1'b1, 0, 1'b0, 1'b0, 0, 102);
    send(1'b1, 2, 1'b0, 1'b0, 0, 103);
    send(1'b1, 0, 1'b0, 1'b0, 0, 104);
    send(1'b1, 2, 1'b0, 1'b1, 0, 105);
    send(1'b1, 0, 1'b0, 1'b1, 0, 106);
    idle(4);

    // Orphan body on idle vc3 (bad VC on the 3-VC instance).
    do_reset(0, 0);
    send(1'b1, 3, 1'b0, 1'b0, 0, 200);
    idle(4);

    // Nested head aborts the open packet.
    do_reset(1, 1);
    send(1'b1, 0, 1'b1, 1'b0, 0, 300);
    send(1'b1, 0, 1'b0, 1'b0, 0, 301);
    send(1'b1, 0, 1'b1, 1'b1, 0, 302);
    idle(3);

    // Misrouted packet still counts; then a clean packet on vc3.
    do_reset(2, 2);
    send(1'b1, 0, 1'b1, 1'b1, 1, 400);
    send(1'b1, 3, 1'b1, 1'b0, 0, 401);
    send(1'b1, 3, 1'b0, 1'b0, 0, 402);
    send(1'b1, 3, 1'b0, 1'b1, 0, 403);
    idle(4);

    // Reset mid-packet with credits in flight, then reuse the VC.
    do_reset(1, 1);
    send(1'b1, 1, 1'b1, 1'b0, 0, 500);
    send(1'b1, 1, 1'b0, 1'b0, 0, 501);
    do_reset(1, 1);
    idle(4);
    send(1'b1, 1, 1'b1, 1'b0, 0, 510);
    send(1'b1, 1, 1'b0, 1'b1, 0, 511);
    idle(3);

    // Randomized traffic; the 4-bit instance saturates along the way.
    for (int r = 0; r < 3; r++) begin
      do_reset(int'($urandom_range(0, 12)), int'($urandom_range(0, 15)));
      for (int i = 0; i < 150; i++) begin
        int dsel = int'($urandom_range(0, 3));
        send($urandom_range(0, 9) < 7,
             int'($urandom_range(0, 3)),
             $urandom_range(0, 9) < 4,
             $urandom_range(0, 9) < 5,
             (dsel == 0) ? 0 : (dsel == 1) ? 5 : int'($urandom_range(0, 15)),
             int'($urandom_range(0, 65535)));
      end
      idle(5);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
